// File: rtl/io_ctrl_pkg.sv
// io_ctrl_pkg: opcodes and FSM states shared by the IO controller files
package io_ctrl_pkg;
  localparam logic [5:0] OP_IN  = 6'b011101;
  localparam logic [5:0] OP_OUT = 6'b100000;
  localparam logic [5:0] OP_HLT = 6'b011100;
  typedef enum logic [1:0] {IDLE, IN_WAIT, IN_DONE, HALT} state_t;
endpackage

// File: rtl/io_debounce.sv
// io_debounce: confirm conditioning (sync, optional IO_CTRL_DEBOUNCE_EN counter) and press pulse
module io_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic press
);
  logic sync1_q, sync2_q, prev_q, level;
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("io_debounce: DEBOUNCE_CYCLES must be at least 1");
  end
  // two-flop synchroniser for the raw button, plus last conditioned level for edge detect
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      prev_q  <= level;
    end
  end
`ifdef IO_CTRL_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic level_q, level_d;
  // count consecutive samples that disagree with the level; flip once enough accumulate
  always_comb begin
    cnt_d   = (sync2_q == level_q) ? '0 : cnt_q + 1'b1;
    level_d = level_q;
    if (sync2_q != level_q && cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end
  end
  // debounce counter and filtered level
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end
  assign level = level_q;
`else
  assign level = sync2_q;
`endif
  assign press = level & ~prev_q;
endmodule

// File: rtl/io_controller.sv
// io_controller: CPU IN/OUT/HLT handler with stall, display channels and LEDs (IO_CTRL_DEBOUNCE_EN adds button debounce)
module io_controller #(
  parameter int DATA_W          = 32,
  parameter int SW_W            = 16,
  parameter int NUM_OUT         = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  localparam int CH_W           = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [5:0]                operation,
  input  logic [CH_W-1:0]           channel,
  input  logic [SW_W-1:0]           switches,
  input  logic                      confirm,
  input  logic [DATA_W-1:0]         IO_RAMOutput,
  output logic                      stall,
  output logic [DATA_W-1:0]         in_data,
  output logic                      in_valid,
  output logic [NUM_OUT*DATA_W-1:0] display,
  output logic [NUM_OUT-1:0]        negLED,
  output logic                      inLED,
  output logic                      outLED,
  output logic                      haltLED
);
  import io_ctrl_pkg::*;
  state_t state_q, state_d;
  logic [DATA_W-1:0] in_data_q, in_data_d;
  logic [NUM_OUT-1:0][DATA_W-1:0] disp_q, disp_d;
  logic [NUM_OUT-1:0] neg_q, neg_d;
  logic out_led_q, out_led_d;
  logic press, out_hit;
  io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clock (clock),
    .reset (reset),
    .btn   (confirm),
    .press (press)
  );
  // next state, input capture and display update; presses outside IN_WAIT fall through unused
  always_comb begin
    state_d   = state_q;
    in_data_d = in_data_q;
    disp_d    = disp_q;
    neg_d     = neg_q;
    out_led_d = 1'b0;
    out_hit   = state_q == IDLE && operation == OP_OUT && 32'(channel) < NUM_OUT;
    case (state_q)
      IDLE:    state_d = (operation == OP_IN) ? IN_WAIT : (operation == OP_HLT) ? HALT : IDLE;
      IN_WAIT: begin
        state_d   = press ? IN_DONE : IN_WAIT;
        in_data_d = press ? DATA_W'(switches) : in_data_q;
      end
      IN_DONE: state_d = IDLE;
      default: state_d = HALT;
    endcase
    if (out_hit) begin
      disp_d[channel] = IO_RAMOutput[DATA_W-1] ? -IO_RAMOutput : IO_RAMOutput;
      neg_d[channel]  = IO_RAMOutput[DATA_W-1];
      out_led_d       = 1'b1;
    end
  end
  // state and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      in_data_q <= '0;
      disp_q    <= '0;
      neg_q     <= '0;
      out_led_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_data_q <= in_data_d;
      disp_q    <= disp_d;
      neg_q     <= neg_d;
      out_led_q <= out_led_d;
    end
  end
  assign stall    = reset && ((state_q == IDLE && operation == OP_IN) || state_q == IN_WAIT || state_q == HALT);
  assign in_valid = state_q == IN_DONE;
  assign in_data  = in_data_q;
  assign display  = disp_q;
  assign negLED   = neg_q;
  assign inLED    = state_q == IN_WAIT || state_q == HALT;
  assign haltLED  = state_q == HALT;
  assign outLED   = out_led_q || state_q == HALT;
endmodule

// File: tb/tb_io_controller.sv
// tb_io_controller: randomized and directed checks of io_controller against a behavioural model
module tb_io_controller;
  import io_ctrl_pkg::*;
  localparam int DW = 32;
  localparam int SW = 16;
  localparam int NO = 4;
  localparam int DB = 20;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [5:0] operation = '0;
  logic [1:0] channel = '0;
  logic [SW-1:0] switches = '0;
  logic confirm = 1'b0;
  logic [DW-1:0] ram = '0;
  logic stall, in_valid, inLED, outLED, haltLED;
  logic [DW-1:0] in_data;
  logic [NO*DW-1:0] display;
  logic [NO-1:0] negLED;
  int errors = 0;
  int checks = 0;
  logic [DW-1:0] m_disp [NO];
  logic m_neg [NO];

  io_controller #(.DATA_W(DW), .SW_W(SW), .NUM_OUT(NO), .DEBOUNCE_CYCLES(DB)) dut (
    .clock(clock), .reset(reset), .operation(operation), .channel(channel),
    .switches(switches), .confirm(confirm), .IO_RAMOutput(ram), .stall(stall),
    .in_data(in_data), .in_valid(in_valid), .display(display), .negLED(negLED),
    .inLED(inLED), .outLED(outLED), .haltLED(haltLED)
  );

  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] magnitude(input logic [DW-1:0] v);
    longint x = longint'(v);
    longint full = longint'(1) << DW;
    return v[DW-1] ? DW'(full - x) : v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NO; i++) begin
      m_disp[i] = '0;
      m_neg[i]  = 1'b0;
    end
  endtask

  task automatic check_display(input string tag);
    logic bad = 1'b0;
    for (int i = 0; i < NO; i++)
      if (display[i*DW +: DW] !== m_disp[i] || negLED[i] !== m_neg[i]) bad = 1'b1;
    check({tag, "_display"}, display, {m_disp[3], m_disp[2], m_disp[1], m_disp[0]});
    check({tag, "_neg"}, negLED, {m_neg[3], m_neg[2], m_neg[1], m_neg[0]});
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_stall"}, stall, 0);
    check({tag, "_in"}, {in_data, in_valid}, 0);
    check({tag, "_disp"}, {display, negLED}, 0);
    check({tag, "_leds"}, {inLED, outLED, haltLED}, 0);
  endtask

  task automatic do_out(input logic [1:0] ch, input logic [DW-1:0] v, input bit halted);
    operation = OP_OUT;
    channel = ch;
    ram = v;
    #1;
    check("out_stall", stall, halted);
    tick();
    if (!halted) begin
      m_disp[ch] = magnitude(v);
      m_neg[ch]  = v[DW-1];
    end
    operation = '0;
    check("out_led", outLED, 1);
    check_display("out");
  endtask

  task automatic do_noop();
    logic [5:0] op;
    do op = 6'($urandom_range(0, 63)); while (op == OP_IN || op == OP_OUT || op == OP_HLT);
    operation = op;
    channel = 2'($urandom);
    ram = $urandom;
    #1;
    check("noop_stall", stall, 0);
    tick();
    operation = '0;
    check("noop_leds", {inLED, outLED, haltLED}, 0);
    check_display("noop");
  endtask

  task automatic start_in(input logic [SW-1:0] sw);
    operation = OP_IN;
    switches = sw;
    #1;
    check("in_comb_stall", stall, 1);
  endtask

  task automatic hold_cycles(input string tag, input int n);
    logic bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (stall !== 1'b1 || in_valid !== 1'b0 || inLED !== 1'b1) bad = 1'b1;
    end
    check(tag, bad, 0);
  endtask

  task automatic press_and_finish(input logic [SW-1:0] sw);
    logic got = 1'b0;
    logic bad = 1'b0;
    confirm = 1'b1;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (in_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (stall !== 1'b1) bad = 1'b1;
    end
    operation = '0;
    check("in_valid_seen", got, 1);
    check("in_stall_until_press", bad, 0);
    check("in_done_stall", stall, 0);
    check("in_data", in_data, {{(DW-SW){1'b0}}, sw});
    tick();
    check("in_valid_one_cycle", in_valid, 0);
    confirm = 1'b0;
    repeat (DB + 5) tick();
  endtask

  initial begin
    clear_model();
    operation = OP_IN;
    #1;
    check_zero_outputs("reset");
    operation = '0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check_zero_outputs("after_reset");

    do_out(2'd2, 32'h0000002A, 0);
    do_out(2'd0, 32'hFFFFFFF6, 0);
    check("neg_ten", display[DW-1:0], 32'h0000000A);
    do_out(2'd1, 32'h80000000, 0);
    check("most_neg", display[DW +: DW], 32'h80000000);
    tick();
    check("out_led_drop", outLED, 0);

    for (int i = 0; i < 40; i++) begin
      logic [DW-1:0] v;
      case ($urandom_range(0, 4))
        0: v = 32'h80000000;
        1: v = 32'h0;
        2: v = 32'hFFFFFFFF;
        default: v = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) do_noop();
      do_out(2'($urandom_range(0, NO - 1)), v, 0);
    end

    start_in(16'hBEEF);
    hold_cycles("in_wait_100", 100);
    press_and_finish(16'hBEEF);

    for (int i = 0; i < 4; i++) begin
      logic [SW-1:0] sw = SW'($urandom);
      start_in(sw);
      hold_cycles("in_wait_rand", $urandom_range(1, 30));
      press_and_finish(sw);
      check_display("after_in");
    end

    confirm = 1'b1;
    repeat (DB + 5) tick();
    start_in(16'h1357);
    hold_cycles("held_no_press", DB + 10);
    confirm = 1'b0;
    hold_cycles("held_release", DB + 5);
    press_and_finish(16'h1357);

`ifdef IO_CTRL_DEBOUNCE_EN
    start_in(16'h5A5A);
    confirm = 1'b1;
    repeat (10) tick();
    confirm = 1'b0;
    hold_cycles("glitch_ignored", 2 * DB);
    press_and_finish(16'h5A5A);
`endif

    start_in(16'h4321);
    hold_cycles("abort_wait", 5);
    reset = 1'b0;
    #1;
    operation = '0;
    clear_model();
    check_zero_outputs("abort_reset");
    tick();
    reset = 1'b1;
    begin
      logic bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (in_valid !== 1'b0 || stall !== 1'b0 || inLED !== 1'b0) bad = 1'b1;
      end
      check("abort_idle", bad, 0);
    end

    do_out(2'd3, 32'hFFFF0000, 0);
    operation = OP_HLT;
    tick();
    operation = '0;
    check("halt_stall", stall, 1);
    check("halt_leds", {inLED, outLED, haltLED}, 3'b111);
    do_out(2'd3, 32'h00000011, 1);
    do_out(2'd0, 32'h00000022, 1);
    operation = OP_IN;
    confirm = 1'b1;
    begin
      logic bad = 1'b0;
      for (int i = 0; i < DB + 10; i++) begin
        tick();
        if (in_valid !== 1'b0 || stall !== 1'b1 || haltLED !== 1'b1) bad = 1'b1;
      end
      check("halt_sticky", bad, 0);
    end
    confirm = 1'b0;
    operation = '0;
    reset = 1'b0;
    #1;
    clear_model();
    check_zero_outputs("halt_reset");
    tick();
    reset = 1'b1;
    tick();
    check("post_halt_leds", {stall, inLED, outLED, haltLED}, 0);
    do_out(2'd1, 32'h00000007, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/io_controller.md
IO_CONTROLLER -- requirements
Module: io_controller

Interface
REQ-001 The block SHALL take parameters: DATA_W, default 32, datapath width; SW_W, default 16, switch width, at most DATA_W; NUM_OUT, default 4, output display channels; DEBOUNCE_CYCLES, default 50000, stable cycles required on confirm.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 The block SHALL have these ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset
- operation  in  6  current opcode
- channel  in  clog2(NUM_OUT)  OUT target channel
- switches  in  SW_W  user input value
- confirm  in  1  raw asynchronous push-button, active-high
- IO_RAMOutput  in  DATA_W  two's-complement value to display
- stall  out  1  CPU hold request
- in_data  out  DATA_W  captured input value
- in_valid  out  1  one-cycle capture strobe
- display  out  NUM_OUT*DATA_W  per-channel magnitudes
- negLED  out  NUM_OUT  per-channel sign
- inLED, outLED, haltLED  out  1  status indicators

Function
REQ-004 Opcodes SHALL be IN=6'b011101, OUT=6'b100000 and HLT=6'b011100; all other opcodes are no-ops.
REQ-005 The FSM SHALL have states IDLE, IN_WAIT, IN_DONE and HALT.
REQ-006 In IDLE with operation==IN, the FSM SHALL go to IN_WAIT, and stall SHALL be 1 combinationally in that same cycle.
REQ-007 In IN_WAIT, stall SHALL be 1 until a confirm press event occurs.
- A press event is a rising edge of the conditioned confirm signal.
REQ-008 On a press event in IN_WAIT, the block SHALL load in_data with switches zero-extended to DATA_W and go to IN_DONE.
REQ-009 In IN_DONE, the block SHALL drive stall=0 and in_valid=1 for exactly one cycle, then return to IDLE.
REQ-010 Press events in any state other than IN_WAIT SHALL be discarded.
- A button already held when IN begins SHALL NOT satisfy it.
REQ-011 In IDLE with operation==OUT, the selected channel SHALL register on the next clock edge:
- if IO_RAMOutput MSB is 0: display = IO_RAMOutput, negLED = 0;
- otherwise: display = -IO_RAMOutput (DATA_W-bit wrap), negLED = 1.
REQ-012 Channels other than the selected one SHALL hold their values.
REQ-013 For OUT with the most negative value, the block SHALL display 1 followed by zeros, with negLED = 1.
REQ-014 A channel index of NUM_OUT or above SHALL leave all channels unchanged.
REQ-015 OUT SHALL never assert stall.
REQ-016 In IDLE with operation==HLT, the FSM SHALL enter HALT. HALT is sticky until reset.
- In HALT, stall = 1 and all opcodes are ignored.
REQ-017 LED outputs SHALL follow the state:
- inLED = 1 in IN_WAIT or HALT;
- haltLED = 1 in HALT;
- outLED = 1 for the cycle after an OUT update, and in HALT.
REQ-018 Opcodes seen in IN_WAIT or IN_DONE SHALL be ignored.
- The CPU holds the opcode while stall is 1.

Reset
REQ-019 While reset is low, the block SHALL hold state=IDLE, and all outputs SHALL be 0: stall, in_data, in_valid, display, negLED and the LEDs.
REQ-020 Reset asserted during IN_WAIT SHALL abort the input, and the FSM SHALL return to IDLE with no in_valid.
REQ-021 Reset SHALL be released synchronously to clock by the surrounding reset bridge; the block SHALL NOT need its own release synchroniser.

Configuration
REQ-022 When macro IO_CTRL_DEBOUNCE_EN is defined, confirm SHALL pass through a 2-flop synchroniser and then a counter.
- The conditioned level changes only after DEBOUNCE_CYCLES consecutive identical samples.
REQ-023 When IO_CTRL_DEBOUNCE_EN is undefined, the conditioned level SHALL be the 2-flop synchroniser output alone, and DEBOUNCE_CYCLES SHALL be unused.

Structure
REQ-024 Package io_ctrl_pkg SHALL hold:
- the opcode constants OP_IN, OP_OUT and OP_HLT;
- the FSM state enum.
REQ-025 The block SHALL have exactly one sub-module, io_debounce, containing the synchroniser, the optional counter and the rising-edge detector.
- io_debounce outputs a one-cycle press pulse.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Reset, then OUT channel 2 with 0x0000002A -> display[2]=0x2A and negLED[2]=0 one cycle later; other channels stay 0.
- OUT channel 0 with 0xFFFFFFF6 -> display[0]=0x0000000A, negLED[0]=1; OUT 0x80000000 -> 0x80000000, negLED=1.
- IN with switches=0xBEEF, press confirm after 100 cycles -> stall high until the press is recognised, then in_data=0x0000BEEF and in_valid pulses one cycle.
- Confirm held before IN, released, pressed again -> only the second press completes IN; with debounce enabled, a 10-cycle glitch is ignored.
- HLT -> stall=1 and inLED, outLED and haltLED all 1; a following OUT does not change display; reset restores IDLE.
- Reset pulsed during IN_WAIT -> stall=0, in_valid never asserted, state IDLE.
